// File: rtl/watch_pkg.sv
// Shared constants and the BCD step helper for the watch timekeeper.
// Values are packed BCD bytes {tens, ones}.
package watch_pkg;

  localparam int         SYNC_STAGES_DFLT = 2;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] HR24_MAX = 8'h23;
  localparam logic [7:0] HR12_MAX = 8'h12;
  localparam logic [7:0] HR12_PRE = 8'h11;
  localparam logic [7:0] HR12_MIN = 8'h01;
  localparam logic [7:0] BCD_ZERO = 8'h00;
  localparam logic [7:0] HR12_RST = 8'h12;

  typedef struct packed {
    logic       wrap;
    logic [7:0] val;
  } bcd_step_t;

  // Increment a packed BCD value, wrapping to 00 once it reaches max_v.
  function automatic bcd_step_t bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    bcd_step_t r;
    if (v == max_v) begin
      r.wrap = 1'b1;
      r.val  = 8'h00;
    end else if (v[3:0] == 4'h9) begin
      r.wrap = 1'b0;
      r.val  = {v[7:4] + 4'h1, 4'h0};
    end else begin
      r.wrap = 1'b0;
      r.val  = {v[7:4], v[3:0] + 4'h1};
    end
    return r;
  endfunction

endpackage

// File: rtl/tick_edge_sync.sv
// Synchronises the divided seconds square wave and turns each rising edge
// into a one-cycle tick, masked until the chain has filled after reset.
module tick_edge_sync
  import watch_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic sec_sq,
  input  logic hold,
  output logic tick_now,
  output logic tick
);

  localparam int             PW        = $clog2(SYNC_STAGES + 2);
  localparam logic [PW-1:0]  PRIME_CYC = PW'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [PW-1:0]          prime_q, prime_d;
  logic                   tick_q, tick_d;
  logic                   primed_s;
  logic                   edge_s;

  // Next-state for the sync chain, edge history, priming count and tick.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], sec_sq};
    prev_d   = sync_q[SYNC_STAGES-1];
    primed_s = (prime_q == PRIME_CYC);
    if (primed_s) begin
      prime_d = prime_q;
    end else begin
      prime_d = prime_q + PW'(1);
    end
    edge_s   = sync_q[SYNC_STAGES-1] & ~prev_q & primed_s;
    tick_now = edge_s & ~hold;
    tick_d   = tick_now;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      prime_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      prime_q <= prime_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/watch_timekeeper.sv
// Time-of-day keeper: BCD sec/min/hr counters advanced by the seconds tick,
// with a set mode for manual minute/hour adjustment.
module watch_timekeeper
  import watch_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DFLT,
  parameter bit MODE_24H    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_sq,
  input  logic       set_en,
  input  logic       inc_min,
  input  logic       inc_hr,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hr_bcd,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_roll
);

  localparam logic [7:0] HR_RST = MODE_24H ? BCD_ZERO : HR12_RST;

  logic [7:0] sec_q, sec_d, min_q, min_d, hr_q, hr_d;
  logic       pm_q, pm_d, day_roll_q, day_roll_d, set_seen_q, set_seen_d;
  logic       tick_now_s;
  logic [7:0] hr_next_s;
  logic       pm_next_s, midnight_s;
  bcd_step_t  sec_step_s, min_step_s;

  tick_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .sec_sq   (sec_sq),
    .hold     (set_en),
    .tick_now (tick_now_s),
    .tick     (sec_tick)
  );

  // midnight_s flags the hour step that lands on the start of a new day.
  if (MODE_24H) begin : g_24h
    bcd_step_t hr_step_s;
    // 24h hour step: 23 wraps to 00.
    always_comb begin
      hr_step_s  = bcd_inc(hr_q, HR24_MAX);
      hr_next_s  = hr_step_s.val;
      pm_next_s  = 1'b0;
      midnight_s = hr_step_s.wrap;
    end
  end else begin : g_12h
    bcd_step_t hr_step_s;
    // 12h hour step: 12 -> 01 keeps pm, 11 -> 12 toggles it.
    always_comb begin
      hr_step_s  = bcd_inc(hr_q, HR12_MAX);
      midnight_s = (hr_q == HR12_PRE) && pm_q;
      if (hr_q == HR12_MAX) begin
        hr_next_s = HR12_MIN;
        pm_next_s = pm_q;
      end else if (hr_q == HR12_PRE) begin
        hr_next_s = HR12_MAX;
        pm_next_s = ~pm_q;
      end else begin
        hr_next_s = hr_step_s.val;
        pm_next_s = pm_q;
      end
    end
  end

  // Counter next-state: set mode edits, run mode carries sec -> min -> hr.
  always_comb begin
    sec_step_s = bcd_inc(sec_q, SEC_MAX);
    min_step_s = bcd_inc(min_q, SEC_MAX);
    sec_d      = sec_q;
    min_d      = min_q;
    hr_d       = hr_q;
    pm_d       = pm_q;
    day_roll_d = 1'b0;
    set_seen_d = set_en;
    if (set_en) begin
      if (!set_seen_q) begin
        sec_d = BCD_ZERO;
      end else begin
        sec_d = sec_q;
      end
      if (inc_min) begin
        min_d = min_step_s.val;
      end else begin
        min_d = min_q;
      end
      if (inc_hr) begin
        hr_d = hr_next_s;
        pm_d = pm_next_s;
      end else begin
        hr_d = hr_q;
        pm_d = pm_q;
      end
    end else if (tick_now_s) begin
      sec_d = sec_step_s.val;
      if (sec_step_s.wrap) begin
        min_d = min_step_s.val;
        if (min_step_s.wrap) begin
          hr_d       = hr_next_s;
          pm_d       = pm_next_s;
          day_roll_d = midnight_s;
        end else begin
          hr_d = hr_q;
        end
      end else begin
        min_d = min_q;
      end
    end else begin
      sec_d = sec_q;
    end
  end

  // Time registers; reset overrides any coincident tick or set input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q      <= BCD_ZERO;
      min_q      <= BCD_ZERO;
      hr_q       <= HR_RST;
      pm_q       <= 1'b0;
      day_roll_q <= 1'b0;
      set_seen_q <= 1'b0;
    end else begin
      sec_q      <= sec_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      pm_q       <= pm_d;
      day_roll_q <= day_roll_d;
      set_seen_q <= set_seen_d;
    end
  end

  assign sec_bcd  = sec_q;
  assign min_bcd  = min_q;
  assign hr_bcd   = hr_q;
  assign pm       = pm_q;
  assign day_roll = day_roll_q;

endmodule

// File: tb/tb_watch_timekeeper.sv
// Bench for watch_timekeeper: a 24h and a 12h instance share stimulus and are
// checked against one seconds-of-day model through a tick scoreboard.
module tb_watch_timekeeper;

  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst, sec_sq, set_en, inc_min, inc_hr;
  logic [7:0] sec_a, min_a, hr_a, sec_b, min_b, hr_b;
  logic       pm_a, tick_a, roll_a, pm_b, tick_b, roll_b;

  watch_timekeeper #(.SYNC_STAGES(SYNC_STAGES), .MODE_24H(1'b1)) dut_24 (
    .clk(clk), .rst(rst), .sec_sq(sec_sq), .set_en(set_en), .inc_min(inc_min),
    .inc_hr(inc_hr), .sec_bcd(sec_a), .min_bcd(min_a), .hr_bcd(hr_a), .pm(pm_a),
    .sec_tick(tick_a), .day_roll(roll_a));

  watch_timekeeper #(.SYNC_STAGES(SYNC_STAGES), .MODE_24H(1'b0)) dut_12 (
    .clk(clk), .rst(rst), .sec_sq(sec_sq), .set_en(set_en), .inc_min(inc_min),
    .inc_hr(inc_hr), .sec_bcd(sec_b), .min_bcd(min_b), .hr_bcd(hr_b), .pm(pm_b),
    .sec_tick(tick_b), .day_roll(roll_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] sec, min, hr24, hr12;
    logic       pm;
    logic       roll;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   h = 0, m = 0, s = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [7:0] hr12_of(input int hh);
    int x;
    x = hh % 12;
    if (x == 0) x = 12;
    return to_bcd(x);
  endfunction

  task automatic model_tick(output logic roll);
    roll = 1'b0;
    s++;
    if (s == 60) begin
      s = 0;
      m++;
      if (m == 60) begin
        m = 0;
        h++;
        if (h == 24) begin
          h = 0;
          roll = 1'b1;
        end
      end
    end
  endtask

  task automatic check_now(input string tag);
    check_eq({tag, "_sec24"}, sec_a, to_bcd(s));
    check_eq({tag, "_min24"}, min_a, to_bcd(m));
    check_eq({tag, "_hr24"},  hr_a,  to_bcd(h));
    check_eq({tag, "_pm24"},  pm_a,  1'b0);
    check_eq({tag, "_sec12"}, sec_b, to_bcd(s));
    check_eq({tag, "_min12"}, min_b, to_bcd(m));
    check_eq({tag, "_hr12"},  hr_b,  hr12_of(h));
    check_eq({tag, "_pm12"},  pm_b,  (h >= 12) ? 1'b1 : 1'b0);
  endtask

  // One sec_sq period (2 high, 2 low); a tick is expected only outside set mode.
  task automatic sec_edge();
    exp_t e;
    logic roll;
    sec_sq = 1'b1;
    if (!set_en) begin
      model_tick(roll);
      e.cyc  = cyc + SYNC_STAGES + 1;
      e.sec  = to_bcd(s);
      e.min  = to_bcd(m);
      e.hr24 = to_bcd(h);
      e.hr12 = hr12_of(h);
      e.pm   = (h >= 12) ? 1'b1 : 1'b0;
      e.roll = roll;
      sb_q.push_back(e);
    end
    repeat (2) begin @(posedge clk); #1; end
    sec_sq = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic press(input logic mi, input logic hi, input int n);
    for (int i = 0; i < n; i++) begin
      inc_min = mi;
      inc_hr  = hi;
      if (mi) m = (m + 1) % 60;
      if (hi) h = (h + 1) % 24;
      @(posedge clk); #1;
    end
    inc_min = 1'b0;
    inc_hr  = 1'b0;
  endtask

  task automatic set_enter();
    set_en = 1'b1;
    s = 0;
    @(posedge clk); #1;
  endtask

  task automatic set_exit();
    set_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic preload(input int hh, input int mm, input int ss);
    set_enter();
    press(1'b0, 1'b1, (hh - h + 24) % 24);
    press(1'b1, 1'b0, (mm - m + 60) % 60);
    set_exit();
    for (int i = 0; i < ss; i++) sec_edge();
  endtask

  // Tick monitor: pops the scoreboard on every tick, including latency check.
  always @(negedge clk) begin
    if (tick_a === 1'b1 || tick_b === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_eq("spurious_tick", {30'd0, tick_a, tick_b}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_eq("tick_cycle", cyc, mon_e.cyc);
        check_eq("tick_24", tick_a, 1'b1);
        check_eq("tick_12", tick_b, 1'b1);
        check_eq("tk_sec24", sec_a, mon_e.sec);
        check_eq("tk_min24", min_a, mon_e.min);
        check_eq("tk_hr24", hr_a, mon_e.hr24);
        check_eq("tk_pm24", pm_a, 1'b0);
        check_eq("tk_roll24", roll_a, mon_e.roll);
        check_eq("tk_sec12", sec_b, mon_e.sec);
        check_eq("tk_min12", min_b, mon_e.min);
        check_eq("tk_hr12", hr_b, mon_e.hr12);
        check_eq("tk_pm12", pm_b, mon_e.pm);
        check_eq("tk_roll12", roll_b, mon_e.roll);
      end
    end else if (roll_a === 1'b1 || roll_b === 1'b1) begin
      check_eq("roll_no_tick", {30'd0, roll_a, roll_b}, 32'd0);
    end
  end

  initial begin
    rst = 1'b1; sec_sq = 1'b1; set_en = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check_now("rst");
    check_eq("rst_tick", {tick_a, tick_b}, 2'b00);
    check_eq("rst_roll", {roll_a, roll_b}, 2'b00);

    // sec_sq already high at release: priming must suppress the tick.
    rst = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    check_now("prime");
    sec_sq = 1'b0;
    repeat (4) begin @(posedge clk); #1; end

    // Midnight rollover in 24h (11pm -> 12am in 12h).
    preload(23, 59, 58);
    sec_edge();
    sec_edge();
    check_now("midnight");

    // Set-mode editing at 10:37:42.
    preload(10, 37, 42);
    set_enter();
    check_now("set_clear");
    sec_edge();
    sec_edge();
    press(1'b1, 1'b0, 23);
    check_now("set_min_wrap");
    press(1'b1, 1'b1, 1);
    check_now("set_both");
    set_exit();
    sec_edge();

    // Noon, then midnight via 12h representation.
    preload(11, 59, 59);
    sec_edge();
    check_now("noon");
    preload(23, 59, 59);
    sec_edge();
    check_now("midnight2");

    // Reset coincident with a tick and inc_hr.
    preload(5, 6, 7);
    sec_sq = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    inc_hr = 1'b1;
    @(posedge clk); #1;
    h = 0; m = 0; s = 0;
    check_eq("rstmid_tick", {tick_a, tick_b}, 2'b00);
    check_now("rstmid");
    rst = 1'b0;
    inc_hr = 1'b0;
    sec_sq = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    sec_edge();

    repeat (5) begin @(posedge clk); #1; end
    check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
